// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 Set-2 scan-code parser: parser states,
// prefix / control byte values, modifier codes and modifier bit positions.
package ps2_kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } state_t;

  // Sequence prefixes
  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_E1 = 8'hE1;
  localparam logic [7:0] PFX_F0 = 8'hF0;

  // Keyboard control / status bytes
  localparam logic [7:0] CTL_ACK    = 8'hFA;
  localparam logic [7:0] CTL_BAT_OK = 8'hAA;
  localparam logic [7:0] CTL_ECHO   = 8'hEE;
  localparam logic [7:0] CTL_RESEND = 8'hFE;
  localparam logic [7:0] CTL_ERR0   = 8'h00;
  localparam logic [7:0] CTL_ERR1   = 8'hFF;

  // Pause: E1 plus seven more bytes; the count holds bytes seen so far
  localparam logic [7:0] PAUSE_CODE = 8'h77;
  localparam logic [2:0] PAUSE_LAST = 3'd7;

  // Modifier scan codes (meaning depends on the E0 prefix)
  localparam logic [7:0] MC_SHIFT_L = 8'h12;
  localparam logic [7:0] MC_SHIFT_R = 8'h59;
  localparam logic [7:0] MC_CTRL    = 8'h14;
  localparam logic [7:0] MC_ALT     = 8'h11;
  localparam logic [7:0] MC_GUI_L   = 8'h1F;
  localparam logic [7:0] MC_GUI_R   = 8'h27;

  // Bit positions in the modifiers vector
  localparam logic [2:0] MB_LSHIFT = 3'd0;
  localparam logic [2:0] MB_RSHIFT = 3'd1;
  localparam logic [2:0] MB_LCTRL  = 3'd2;
  localparam logic [2:0] MB_RCTRL  = 3'd3;
  localparam logic [2:0] MB_LALT   = 3'd4;
  localparam logic [2:0] MB_RALT   = 3'd5;
  localparam logic [2:0] MB_LGUI   = 3'd6;
  localparam logic [2:0] MB_RGUI   = 3'd7;

  function automatic logic is_ctl(input logic [7:0] b);
    return (b == CTL_ACK) || (b == CTL_BAT_OK) || (b == CTL_ECHO) ||
           (b == CTL_RESEND) || (b == CTL_ERR0) || (b == CTL_ERR1);
  endfunction

  // Returns {hit, bit_index} for a final code and its E0 flag
  function automatic logic [3:0] mod_lookup(input logic [7:0] code, input logic ext);
    logic [3:0] r;
    r = 4'b0000;
    if (!ext) begin
      case (code)
        MC_SHIFT_L: r = {1'b1, MB_LSHIFT};
        MC_SHIFT_R: r = {1'b1, MB_RSHIFT};
        MC_CTRL:    r = {1'b1, MB_LCTRL};
        MC_ALT:     r = {1'b1, MB_LALT};
        default:    r = 4'b0000;
      endcase
    end else begin
      case (code)
        MC_CTRL:  r = {1'b1, MB_RCTRL};
        MC_ALT:   r = {1'b1, MB_RALT};
        MC_GUI_L: r = {1'b1, MB_LGUI};
        MC_GUI_R: r = {1'b1, MB_RGUI};
        default:  r = 4'b0000;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_seq_timer.sv
// Sequence watchdog: up-counter cleared on every received byte, running only
// while enabled, with a one-cycle expired pulse on its last count.
module ps2_seq_timer #(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int TMR_W          = 22
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMR_W-1:0] count_reg;

  // A byte arriving on the final count wins over the timeout
  assign expired = en && !clr && (count_reg == TMR_W'(TIMEOUT_CYCLES - 1));

  // Count idle cycles; restart from zero on clear, disable or expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr || !en || expired) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_scancode_parser.sv
// Folds Set-2 byte sequences (E0 / F0 / E1 prefixes) into single key events,
// tracks modifier keys, and separates keyboard control bytes onto a strobe.
module ps2_scancode_parser
  import ps2_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int TMR_W          = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_valid,
  input  logic [7:0] code_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_rel,
  output logic       evt_pause,
  output logic [7:0] modifiers,
  output logic       ctl_valid,
  output logic [7:0] ctl_code,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       seq_err
);

  state_t     state_reg, state_next;
  logic [2:0] pcnt_reg, pcnt_next;
  logic       tmr_expired;

  logic       gen, gen_ext, gen_rel, gen_pause, ctl_hit, err;
  logic [7:0] gen_code;
  logic [3:0] mod_hit;

  logic in_ext, in_brk, bad_prefix, is_prefix;

  assign in_ext    = (state_reg == ST_EXT) || (state_reg == ST_EXT_BRK);
  assign in_brk    = (state_reg == ST_BRK) || (state_reg == ST_EXT_BRK);
  assign is_prefix = (code_data == PFX_E0) || (code_data == PFX_E1) || (code_data == PFX_F0);
  // E0/E1 are only legal first; F0 may not repeat
  assign bad_prefix = (state_reg != ST_IDLE) && (state_reg != ST_PAUSE) &&
                      ((code_data == PFX_E0) || (code_data == PFX_E1) ||
                       ((code_data == PFX_F0) && in_brk));

  ps2_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (code_valid),
    .en     (state_reg != ST_IDLE),
    .expired(tmr_expired)
  );

  // State register and pause byte counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      pcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pcnt_reg  <= pcnt_next;
    end
  end

  // Next-state decode and event/control/error generation for the current byte
  always_comb begin
    state_next = state_reg;
    pcnt_next  = pcnt_reg;
    gen        = 1'b0;
    gen_code   = code_data;
    gen_ext    = 1'b0;
    gen_rel    = 1'b0;
    gen_pause  = 1'b0;
    ctl_hit    = 1'b0;
    err        = 1'b0;
    if (code_valid) begin
      if (state_reg == ST_PAUSE) begin
        // Pause body bytes are counted, never inspected
        if (pcnt_reg == PAUSE_LAST) begin
          gen        = 1'b1;
          gen_code   = PAUSE_CODE;
          gen_pause  = 1'b1;
          state_next = ST_IDLE;
          pcnt_next  = '0;
        end else begin
          pcnt_next = pcnt_reg + 3'd1;
        end
      end else if ((state_reg == ST_IDLE) || bad_prefix) begin
        // A misplaced prefix restarts the sequence as though seen in IDLE
        err        = bad_prefix;
        state_next = ST_IDLE;
        if (code_data == PFX_E0) begin
          state_next = ST_EXT;
        end else if (code_data == PFX_F0) begin
          state_next = ST_BRK;
        end else if (code_data == PFX_E1) begin
          state_next = ST_PAUSE;
          pcnt_next  = 3'd1;
        end else if (is_ctl(code_data)) begin
          ctl_hit = 1'b1;
        end else begin
          gen = 1'b1;
        end
      end else if (code_data == PFX_F0) begin
        state_next = ST_EXT_BRK;
      end else if (is_ctl(code_data)) begin
        err        = 1'b1;
        ctl_hit    = 1'b1;
        state_next = ST_IDLE;
      end else begin
        state_next = ST_IDLE;
        // E0 12 / E0 59 are the keyboard's fake shifts: swallow them
        if (!(in_ext && ((code_data == MC_SHIFT_L) || (code_data == MC_SHIFT_R)))) begin
          gen     = !is_prefix;
          gen_ext = in_ext;
          gen_rel = in_brk;
        end
      end
    end else if (tmr_expired) begin
      state_next = ST_IDLE;
      pcnt_next  = '0;
      err        = 1'b1;
    end
  end

  assign mod_hit = mod_lookup(gen_code, gen_ext);

  // Control strobe, error pulse and live modifier state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_valid <= 1'b0;
      ctl_code  <= '0;
      seq_err   <= 1'b0;
      modifiers <= '0;
    end else begin
      ctl_valid <= ctl_hit;
      seq_err   <= err;
      if (ctl_hit) begin
        ctl_code <= code_data;
      end
      if (gen && !gen_pause && mod_hit[3]) begin
        modifiers[mod_hit[2:0]] <= !gen_rel;
      end
    end
  end

  // Single-entry event register with drop-on-full and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_code  <= '0;
      evt_ext   <= 1'b0;
      evt_rel   <= 1'b0;
      evt_pause <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (gen && (!evt_valid || evt_ready)) begin
        evt_valid <= 1'b1;
        evt_code  <= gen_code;
        evt_ext   <= gen_ext;
        evt_rel   <= gen_rel;
        evt_pause <= gen_pause;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (gen && evt_valid && !evt_ready) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ps2_scancode_parser.md
Name: ps2_scancode_parser

Overview:
Downstream consumer of the PS/2 frame decoder's byte stream (data/valid pulse). Folds Set-2 multi-byte sequences (E0 extended prefix, F0 break prefix, E1 Pause) into single key events carrying code, extended and release flags. Tracks live modifier state. Presents events over a valid/ready handshake, and presents keyboard control bytes on a separate strobe, for the host-side FIFO/bus logic.

Parameters:
- TIMEOUT_CYCLES, 2500000: idle cycles after a prefix byte before the parser abandons the sequence (100 ms at 25 MHz).
- TMR_W, 22: width of the timeout counter; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- code_valid, input, 1: one-cycle strobe; code_data is a new received byte.
- code_data, input, 8: received scan byte.
- evt_valid, output, 1: key event available.
- evt_ready, input, 1: consumer accepts event.
- evt_code, output, 8: final scan code.
- evt_ext, output, 1: sequence carried an E0 prefix.
- evt_rel, output, 1: sequence carried an F0 prefix (key released).
- evt_pause, output, 1: event is the Pause key.
- modifiers, output, 8: {RGUI,LGUI,RALT,LALT,RCTRL,LCTRL,RSHIFT,LSHIFT}; 1 = held.
- ctl_valid, output, 1: one-cycle strobe for a control byte.
- ctl_code, output, 8: control byte.
- overflow, output, 1: sticky; an event was dropped.
- ovf_clr, input, 1: clears overflow.
- seq_err, output, 1: one-cycle pulse on a timeout or an illegal prefix order.

Behaviour:
- Reset: all outputs 0; state IDLE; timer 0; modifiers 0.
- States: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), PAUSE (E1 seen; count 1..7).
- IDLE transitions:
  - E0 goes to EXT.
  - F0 goes to BRK.
  - E1 goes to PAUSE with count=1.
  - Control bytes {FA, AA, EE, FE, 00, FF} pulse ctl_valid/ctl_code on the next cycle and stay in IDLE.
  - Any other byte emits a make event.
- EXT: F0 goes to EXT_BRK; any other byte emits an extended make.
- BRK: emits a break.
- EXT_BRK: emits an extended break.
- Prefix in the wrong place is an error: E0 or E1 while in EXT, BRK or EXT_BRK, or F0 while in BRK or EXT_BRK. The state restarts as if from IDLE on that byte, and seq_err pulses.
- Control bytes received in a non-IDLE, non-PAUSE state abort the sequence to IDLE, pulse seq_err and ctl_valid.
- PAUSE: every byte increments the count, contents are not checked. The 8th byte (count reaching 7) emits evt_code=77, pause=1, ext=0, rel=0, and returns to IDLE.
- Fake shift: E0 12 and E0 59, in both make and break form, are discarded. No event, no modifier change, return to IDLE.
- Modifier codes (no E0 prefix): LSHIFT 12, RSHIFT 59, LCTRL 14, LALT 11.
- Modifier codes (E0 prefix): RCTRL 14, RALT 11, LGUI 1F, RGUI 27.
- Modifier update: make sets the bit, break clears it. The update happens in the same cycle the event is generated, even if that event is dropped.
- Event latency: evt_* registered, evt_valid high the cycle after the final byte's code_valid.
- evt_valid/evt_* hold stable until a cycle with evt_ready=1, then fall the next cycle.
- Event generated while evt_valid=1 and evt_ready=0: new event dropped, old event kept, overflow set.
- Event generated while evt_valid=1 and evt_ready=1: new event loaded, evt_valid stays 1.
- overflow clears on ovf_clr. If a set and ovf_clr occur in the same cycle, set wins.
- Timeout:
  - Timer clears on every code_valid and counts while state is not IDLE.
  - When the timer reaches TIMEOUT_CYCLES-1: state goes to IDLE, seq_err pulses, no event is emitted.
  - Timer does not run in IDLE.
- Reset mid-sequence discards the partial sequence and clears modifiers and any pending event.
- Bytes arriving back-to-back every cycle are supported (one per clock).

Decomposition:
- Package ps2_kbd_pkg:
  - State enum.
  - Prefix constants E0, E1, F0.
  - Control-byte constants.
  - Modifier code constants and modifier bit indices.
- Sub-module ps2_seq_timer: loadable up-counter with clear, enable and an expired pulse, parameterised by TIMEOUT_CYCLES/TMR_W.
- All remaining logic lives in the parser: FSM, event register, modifier register.

Test Plan:
- Make 1C, break F0 1C, each with ready=1 -> event {1C, ext0, rel0}, then {1C, ext0, rel1}; each evt_valid high exactly 1 cycle.
- E0 14, then E0 F0 14 -> extended events; modifiers=0x08 after the make, 0x00 after the break. Plain 12 sets modifiers=0x01.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event {77, pause=1}; no modifier change.
- Pattern: hold ready=0, then send 1C and 32 -> first event stays (1C), overflow=1, 32 lost. Then ready=1 pulse, then ovf_clr -> overflow=0.
- Byte E0, then TIMEOUT_CYCLES idle cycles (use TIMEOUT_CYCLES=16) -> seq_err pulse, no event. Following 1C decodes as non-extended.
- Byte AA while in IDLE -> ctl_valid pulse with ctl_code=AA, no evt_valid. F0 then rst_n low, release, then 1C -> make event (not a break).
